// File: rtl/drawcon_grid.sv
// ---------------------------------------------------------------------------
// drawcon_grid
//   Pixel colour generator for a breakout-style playfield: border, brick
//   grid, paddle and ball.  Object positions are captured into shadow
//   registers on frame_start, so changes in the middle of a frame never tear
//   the picture.  Rendering is a two-stage pipeline: stage 1 registers the
//   coordinate compares, stage 2 registers the colour.  The brick alive
//   bits are read in stage 2, so a cleared brick disappears from the very
//   next rendered pixel.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   frame_start             one-cycle pulse, latches paddle/ball positions
//   paddle_x/_y, ball_x/_y  object top-left corners (11/10 bits)
//   draw_x/_y, pix_valid_in pixel coordinate being rendered and its strobe
//   hit_valid, hit_row/_col brick-clear request
//   bricks_restore          revive every brick (wins over a coincident hit)
//   draw_r/_g/_b            4-bit colour, zero when pix_valid_out is low
//   pix_valid_out           pix_valid_in delayed by exactly two cycles
//   bricks_left, all_clear  live-brick count and its registered zero flag
// ---------------------------------------------------------------------------
module drawcon_grid #(
    parameter int SCREEN_W   = 1440,
    parameter int SCREEN_H   = 900,
    parameter int BORDER     = 10,
    parameter int PADDLE_W   = 120,
    parameter int PADDLE_H   = 10,
    parameter int BALL_SZ    = 24,
    parameter int BRICK_ROWS = 4,
    parameter int BRICK_COLS = 8,
    parameter int BRICK_W    = 160,
    parameter int BRICK_H    = 30,
    parameter int BRICK_X0   = 80,
    parameter int BRICK_Y0   = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [10:0] paddle_x,
    input  logic [9:0]  paddle_y,
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic [10:0] draw_x,
    input  logic [9:0]  draw_y,
    input  logic        pix_valid_in,
    input  logic        hit_valid,
    input  logic [2:0]  hit_row,
    input  logic [3:0]  hit_col,
    input  logic        bricks_restore,
    output logic [3:0]  draw_r,
    output logic [3:0]  draw_g,
    output logic [3:0]  draw_b,
    output logic        pix_valid_out,
    output logic [7:0]  bricks_left,
    output logic        all_clear
);

    localparam int         BRICK_N     = BRICK_ROWS * BRICK_COLS;
    localparam logic [7:0] BRICK_TOTAL = 8'(BRICK_N);

    // ------------------------------------------------------------------
    // Shadow positions
    // ------------------------------------------------------------------
    logic [10:0] sh_paddle_x;
    logic [9:0]  sh_paddle_y;
    logic [10:0] sh_ball_x;
    logic [9:0]  sh_ball_y;

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_paddle_x <= '0;
            sh_paddle_y <= '0;
            sh_ball_x   <= '0;
            sh_ball_y   <= '0;
        end else if (frame_start) begin
            sh_paddle_x <= paddle_x;
            sh_paddle_y <= paddle_y;
            sh_ball_x   <= ball_x;
            sh_ball_y   <= ball_y;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: coordinate compares.  Everything is widened to 12 bits so
    // right/bottom edges near the screen limit cannot wrap.
    // ------------------------------------------------------------------
    logic [11:0] x12, y12;
    logic [11:0] ball_x12, ball_y12, pad_x12, pad_y12;
    logic        ball_c, paddle_c, border_c, brick_c;
    logic        col_ok, row_ok;
    logic [2:0]  brick_row_c;
    logic [3:0]  brick_col_c;

    assign x12      = {1'b0, draw_x};
    assign y12      = {2'b0, draw_y};
    assign ball_x12 = {1'b0, sh_ball_x};
    assign ball_y12 = {2'b0, sh_ball_y};
    assign pad_x12  = {1'b0, sh_paddle_x};
    assign pad_y12  = {2'b0, sh_paddle_y};

    assign ball_c   = (x12 >= ball_x12) && (x12 <= ball_x12 + 12'(BALL_SZ)) &&
                      (y12 >= ball_y12) && (y12 <= ball_y12 + 12'(BALL_SZ));
    assign paddle_c = (x12 >= pad_x12) && (x12 <= pad_x12 + 12'(PADDLE_W)) &&
                      (y12 >= pad_y12) && (y12 <= pad_y12 + 12'(PADDLE_H));
    assign border_c = (x12 <  12'(BORDER)) || (x12 >= 12'(SCREEN_W - BORDER)) ||
                      (y12 <  12'(BORDER)) || (y12 >= 12'(SCREEN_H - BORDER));

    // Each cell's window stops 2 pixels short of the next cell, so the
    // gap and the area outside the grid both fall out as "no match".
    // NOTE: every combinational output gets a default before the loops so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_ok      = 1'b0;
        row_ok      = 1'b0;
        brick_col_c = '0;
        brick_row_c = '0;
        for (int c = 0; c < BRICK_COLS; c++) begin
            if (x12 >= 12'(BRICK_X0 + c * BRICK_W) &&
                x12 <  12'(BRICK_X0 + (c + 1) * BRICK_W - 2)) begin
                col_ok      = 1'b1;
                brick_col_c = 4'(c);
            end
        end
        for (int r = 0; r < BRICK_ROWS; r++) begin
            if (y12 >= 12'(BRICK_Y0 + r * BRICK_H) &&
                y12 <  12'(BRICK_Y0 + (r + 1) * BRICK_H - 2)) begin
                row_ok      = 1'b1;
                brick_row_c = 3'(r);
            end
        end
        brick_c = col_ok && row_ok;
    end

    logic       s1_valid, s1_ball, s1_paddle, s1_border, s1_brick;
    logic [2:0] s1_row;
    logic [3:0] s1_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_ball   <= 1'b0;
            s1_paddle <= 1'b0;
            s1_border <= 1'b0;
            s1_brick  <= 1'b0;
            s1_row    <= '0;
            s1_col    <= '0;
        end else begin
            s1_valid  <= pix_valid_in;
            s1_ball   <= ball_c;
            s1_paddle <= paddle_c;
            s1_border <= border_c;
            s1_brick  <= brick_c;
            s1_row    <= brick_row_c;
            s1_col    <= brick_col_c;
        end
    end

    // ------------------------------------------------------------------
    // Brick state
    // ------------------------------------------------------------------
    logic [BRICK_N-1:0] alive;
    logic [BRICK_N-1:0] hit_mask;
    logic               hit_ok;

    // Out-of-range row/col never matches a cell, so the mask stays empty.
    always_comb begin
        hit_mask = '0;
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                if (hit_valid && hit_row == 3'(r) && hit_col == 4'(c))
                    hit_mask[r * BRICK_COLS + c] = 1'b1;
            end
        end
        hit_ok = |(hit_mask & alive);
    end

    // NOTE: the alive vector is a small flop bank, not RAM, so it takes an
    // asynchronous reset to "all alive" like any other control register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive       <= '1;
            bricks_left <= BRICK_TOTAL;
            all_clear   <= 1'b0;
        end else if (bricks_restore) begin
            alive       <= '1;
            bricks_left <= BRICK_TOTAL;
            all_clear   <= (BRICK_TOTAL == 8'd0);
        end else if (hit_ok) begin
            alive       <= alive & ~hit_mask;
            bricks_left <= bricks_left - 8'd1;
            all_clear   <= (bricks_left == 8'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select.  Alive bits are read here, not in stage 1,
    // so a clear on one edge is visible on the pixel leaving at the next.
    // ------------------------------------------------------------------
    logic        brick_live;
    logic [11:0] rgb_c;

    always_comb begin
        brick_live = 1'b0;
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                if (s1_row == 3'(r) && s1_col == 4'(c))
                    brick_live = alive[r * BRICK_COLS + c];
            end
        end

        rgb_c = 12'h000;
        if (s1_ball)
            rgb_c = 12'hFFF;
        else if (s1_paddle)
            rgb_c = 12'h0F0;
        else if (s1_brick && brick_live) begin
            case (s1_row[1:0])
                2'd0:    rgb_c = 12'hF00;
                2'd1:    rgb_c = 12'hF80;
                2'd2:    rgb_c = 12'hFF0;
                default: rgb_c = 12'h00F;
            endcase
        end else if (s1_border)
            rgb_c = 12'h0F0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_out <= 1'b0;
            draw_r        <= '0;
            draw_g        <= '0;
            draw_b        <= '0;
        end else begin
            pix_valid_out <= s1_valid;
            if (s1_valid) begin
                draw_r <= rgb_c[11:8];
                draw_g <= rgb_c[7:4];
                draw_b <= rgb_c[3:0];
            end else begin
                draw_r <= '0;
                draw_g <= '0;
                draw_b <= '0;
            end
        end
    end

endmodule

// File: doc/drawcon_grid.md
DRAWCON_GRID -- requirements
Module: drawcon_grid

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
- SCREEN_W, 1440, active width in pixels
- SCREEN_H, 900, active height in pixels
- BORDER, 10, border thickness in pixels
- PADDLE_W, 120, paddle width
- PADDLE_H, 10, paddle height
- BALL_SZ, 24, ball edge length
- BRICK_ROWS, 4, brick grid rows (1..8)
- BRICK_COLS, 8, brick grid columns (1..16)
- BRICK_W, 160, brick cell width (includes 2-px gap)
- BRICK_H, 30, brick cell height (includes 2-px gap)
- BRICK_X0, 80, grid left edge
- BRICK_Y0, 60, grid top edge
REQ-002 The block SHALL expose these ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock, single clock domain
- rst_n, in, 1, asynchronous active-low reset
- frame_start, in, 1, one-cycle pulse; latch object positions
- paddle_x / paddle_y, in, 11 / 10, paddle top-left
- ball_x / ball_y, in, 11 / 10, ball top-left
- draw_x / draw_y, in, 11 / 10, current pixel coordinate
- pix_valid_in, in, 1, draw_x/draw_y valid this cycle
- hit_valid, in, 1, brick-clear request strobe
- hit_row / hit_col, in, 3 / 4, brick to clear
- bricks_restore, in, 1, revive all bricks
- draw_r / draw_g / draw_b, out, 4 each, pixel colour
- pix_valid_out, out, 1, colour outputs valid
- bricks_left, out, 8, count of live bricks
- all_clear, out, 1, high when bricks_left == 0

Function
REQ-003 Positions SHALL be held in shadow registers loaded only on frame_start; rendering SHALL use shadow values, so mid-frame input changes produce no tearing.
REQ-004 Rendering SHALL be a 2-stage pipeline: stage 1 registers coordinate compares, stage 2 registers colour; latency from pix_valid_in to pix_valid_out is exactly 2 cycles, fully pipelined (one pixel per cycle).
REQ-005 When the matching pix_valid_out is low, colour outputs SHALL be 0.
REQ-006 All right-edge sums (e.g. paddle_x+PADDLE_W) SHALL be computed at 12 bits; no wrap-around at screen edges.
REQ-007 Hit regions: ball x in [bx, bx+BALL_SZ], y in [by, by+BALL_SZ]; paddle x in [px, px+PADDLE_W], y in [py, py+PADDLE_H]; all bounds inclusive.
REQ-008 Border region: x < BORDER, or x >= SCREEN_W-BORDER, or y < BORDER, or y >= SCREEN_H-BORDER.
REQ-009 Brick region: x in [BRICK_X0, BRICK_X0+BRICK_COLS*BRICK_W), y in [BRICK_Y0, BRICK_Y0+BRICK_ROWS*BRICK_H); pixel within a cell's last 2 columns or rows is gap (not brick); brick drawn only if its alive bit is set.
REQ-010 Colour priority SHALL be ball (F,F,F) > paddle (0,F,0) > live brick > border (0,F,0) > background (0,0,0).
REQ-011 Brick colour by row mod 4: 0 = (F,0,0), 1 = (F,8,0), 2 = (F,F,0), 3 = (0,0,F).
REQ-012 hit_valid with in-range, live brick SHALL clear that alive bit and decrement bricks_left on the next edge; dead or out-of-range target SHALL be ignored.
REQ-013 bricks_restore SHALL set all alive bits and bricks_left = BRICK_ROWS*BRICK_COLS; when coincident with hit_valid, restore wins.
REQ-014 Alive-bit changes SHALL affect rendering no later than 1 cycle after the updating edge; no frame-sync on alive bits.
REQ-015 all_clear SHALL be registered, equal to (bricks_left == 0).

Reset
REQ-016 On rst_n low (asynchronous): outputs colour 0, pix_valid_out 0, pipeline valid bits 0, shadow positions 0, all bricks alive, bricks_left = BRICK_ROWS*BRICK_COLS, all_clear 0.
REQ-017 Reset asserted mid-frame or mid-hit SHALL abort in-flight pixels; first valid output after release follows a pix_valid_in 2 cycles later.

Verification
REQ-018 Ball at (100,100) latched by frame_start, pixel (124,124) valid -> (F,F,F) 2 cycles later; (125,124) -> (0,0,0).
REQ-019 Ball and paddle overlapping at (700,850), query (710,855) -> ball colour (F,F,F); border pixel (0,500) -> (0,F,0).
REQ-020 Change ball_x mid-frame without frame_start -> rendered ball unchanged until next frame_start.
REQ-021 hit row1 col2 -> bricks_left 31, pixel (400,100) -> background; repeat hit -> count stays 31; gap pixel (238,100) -> background before hit.
REQ-022 Clear all 32 bricks -> all_clear 1; bricks_restore with simultaneous hit_valid -> bricks_left 32, all_clear 0.
REQ-023 Assert rst_n low during streaming pixels -> outputs 0 immediately; after release, bricks all alive, latency 2 restored.
